mem_stage: RTL and testbench

Memory-access pipeline stage that sits between execute and `writeback`. It registers each execute slot and issues load and store requests to the data-memory port using a valid/ready request and a response-valid return. It stalls the upstream pipeline while a request is outstanding and emits an aligned slot to writeback: opcode, targets, ALU results, raw `mem_result`, `addr` and `exc`. Store lane placement is done here. Load lane extraction is done in writeback.

---
 rtl/mem_stage.sv | 184 ++++++++++++++++++
 tb/tb_mem_stage.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute slot, issues one data-memory
// request per load/store, stalls upstream until the response returns, then emits to writeback.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        flush,
  input  logic        bubble_in,
  input  logic [4:0]  opcode_in,
  input  logic [4:0]  tgt_in_1,
  input  logic [4:0]  tgt_in_2,
  input  logic        is_load_in,
  input  logic        is_store_in,
  input  logic        tgts_cr_in,
  input  logic [4:0]  priv_type_in,
  input  logic [1:0]  crmov_mode_type_in,
  input  logic [31:0] alu_result_in_1,
  input  logic [31:0] alu_result_in_2,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  input  logic [7:0]  exc_in,
  output logic        stall_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic        bubble_out,
  output logic [4:0]  opcode_out,
  output logic [4:0]  tgt_out_1,
  output logic [4:0]  tgt_out_2,
  output logic        is_load_out,
  output logic        is_store_out,
  output logic        tgts_cr_out,
  output logic [4:0]  priv_type_out,
  output logic [1:0]  crmov_mode_type_out,
  output logic [31:0] alu_result_out_1,
  output logic [31:0] alu_result_out_2,
  output logic [31:0] mem_result_out,
  output logic [31:0] addr_out,
  output logic [7:0]  exc_out,
  output logic [1:0]  fsm_state
);

  // Memory handshake: a request transfers on a clk_en edge where mem_req && mem_ready;
  // the matching response (load data or store ack) is the single mem_rvalid pulse that follows.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t state;

  assign stall_out = (state != S_IDLE);
  assign fsm_state = state;

  logic is_mem_op;
  assign is_mem_op = !bubble_in && (exc_in == 8'h00) && (is_load_in || is_store_in);

  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = store_data_in;
    if (opcode_in >= 5'd6 && opcode_in <= 5'd8) begin
      if (addr_in[1]) begin
        st_be    = 4'b1100;
        st_wdata = {store_data_in[15:0], 16'h0000};
      end else if (addr_in[0]) begin
        st_be    = 4'b0110;
        st_wdata = {8'h00, store_data_in[15:0], 8'h00};
      end else begin
        st_be    = 4'b0011;
        st_wdata = {16'h0000, store_data_in[15:0]};
      end
    end else if (opcode_in >= 5'd9 && opcode_in <= 5'd11) begin
      st_be    = 4'b0001 << addr_in[1:0];
      st_wdata = {24'h000000, store_data_in[7:0]} << {addr_in[1:0], 3'b000};
    end
  end

  // Slot fields are loaded into the output registers at capture; for memory ops they
  // sit behind bubble_out=1 until the response completes the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= S_IDLE;
      mem_req             <= 1'b0;
      mem_we              <= 1'b0;
      mem_addr            <= 32'h0;
      mem_wdata           <= 32'h0;
      mem_be              <= 4'h0;
      bubble_out          <= 1'b1;
      opcode_out          <= 5'h0;
      tgt_out_1           <= 5'h0;
      tgt_out_2           <= 5'h0;
      is_load_out         <= 1'b0;
      is_store_out        <= 1'b0;
      tgts_cr_out         <= 1'b0;
      priv_type_out       <= 5'h0;
      crmov_mode_type_out <= 2'h0;
      alu_result_out_1    <= 32'h0;
      alu_result_out_2    <= 32'h0;
      mem_result_out      <= 32'h0;
      addr_out            <= 32'h0;
      exc_out             <= 8'h0;
    end else if (clk_en) begin
      case (state)
        S_IDLE: begin
          if (flush) begin
            bubble_out <= 1'b1;
          end else begin
            opcode_out          <= opcode_in;
            tgt_out_1           <= tgt_in_1;
            tgt_out_2           <= tgt_in_2;
            is_load_out         <= is_load_in;
            is_store_out        <= is_store_in;
            tgts_cr_out         <= tgts_cr_in;
            priv_type_out       <= priv_type_in;
            crmov_mode_type_out <= crmov_mode_type_in;
            alu_result_out_1    <= alu_result_in_1;
            alu_result_out_2    <= alu_result_in_2;
            mem_result_out      <= 32'h0;
            addr_out            <= addr_in;
            exc_out             <= exc_in;
            if (is_mem_op) begin
              bubble_out <= 1'b1;
              state      <= S_REQ;
              mem_req    <= 1'b1;
              mem_we     <= is_store_in;
              mem_addr   <= {addr_in[31:2], 2'b00};
              mem_be     <= is_store_in ? st_be : 4'b1111;
              mem_wdata  <= is_store_in ? st_wdata : 32'h0;
            end else begin
              bubble_out <= bubble_in;
            end
          end
        end
        S_REQ: begin
          bubble_out <= 1'b1;
          if (flush || mem_ready) begin
            mem_req <= 1'b0;
          end
          if (flush) begin
            state <= mem_ready ? S_DRAIN : S_IDLE;
          end else if (mem_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush) begin
            bubble_out <= 1'b1;
            state      <= mem_rvalid ? S_IDLE : S_DRAIN;
          end else if (mem_rvalid) begin
            bubble_out <= 1'b0;
            state      <= S_IDLE;
            if (mem_err) begin
              mem_result_out <= 32'h0;
              exc_out        <= is_store_out ? 8'h83 : 8'h82;
            end else begin
              mem_result_out <= mem_rdata;
            end
          end else begin
            bubble_out <= 1'b1;
          end
        end
        S_DRAIN: begin
          bubble_out <= 1'b1;
          if (mem_rvalid) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a transaction-level model predicts emitted slots and
// memory requests; a negedge compare process checks them, plus literal spot checks.
module tb_mem_stage;

  localparam int W  = 161;
  localparam int RW = 69;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [4:0]  tgt1;
    logic [4:0]  tgt2;
    logic        ld;
    logic        st;
    logic        cr;
    logic [4:0]  priv;
    logic [1:0]  crmov;
    logic [31:0] alu1;
    logic [31:0] alu2;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [7:0]  exc;
    logic        bub;
  } in_t;

  logic        clk, rst, clk_en, flush;
  logic        bubble_in, is_load_in, is_store_in, tgts_cr_in;
  logic [4:0]  opcode_in, tgt_in_1, tgt_in_2, priv_type_in;
  logic [1:0]  crmov_mode_type_in;
  logic [31:0] alu_result_in_1, alu_result_in_2, addr_in, store_data_in;
  logic [7:0]  exc_in;
  logic        stall_out, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready, mem_rvalid, mem_err;
  logic [31:0] mem_rdata;
  logic        bubble_out, is_load_out, is_store_out, tgts_cr_out;
  logic [4:0]  opcode_out, tgt_out_1, tgt_out_2, priv_type_out;
  logic [1:0]  crmov_mode_type_out, fsm_state;
  logic [31:0] alu_result_out_1, alu_result_out_2, mem_result_out, addr_out;
  logic [7:0]  exc_out;

  mem_stage dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush),
    .bubble_in(bubble_in), .opcode_in(opcode_in), .tgt_in_1(tgt_in_1), .tgt_in_2(tgt_in_2),
    .is_load_in(is_load_in), .is_store_in(is_store_in), .tgts_cr_in(tgts_cr_in),
    .priv_type_in(priv_type_in), .crmov_mode_type_in(crmov_mode_type_in),
    .alu_result_in_1(alu_result_in_1), .alu_result_in_2(alu_result_in_2),
    .addr_in(addr_in), .store_data_in(store_data_in), .exc_in(exc_in),
    .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err),
    .bubble_out(bubble_out), .opcode_out(opcode_out), .tgt_out_1(tgt_out_1), .tgt_out_2(tgt_out_2),
    .is_load_out(is_load_out), .is_store_out(is_store_out), .tgts_cr_out(tgts_cr_out),
    .priv_type_out(priv_type_out), .crmov_mode_type_out(crmov_mode_type_out),
    .alu_result_out_1(alu_result_out_1), .alu_result_out_2(alu_result_out_2),
    .mem_result_out(mem_result_out), .addr_out(addr_out), .exc_out(exc_out),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0]  exp_q[$];
  logic [RW-1:0] req_q[$];
  logic          req_seen = 1'b0;
  logic [31:0]   lr_addr, lr_wdata;
  logic [3:0]    lr_be;
  logic          lr_we;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [W-1:0] out_slot;
  assign out_slot = {opcode_out, tgt_out_1, tgt_out_2, is_load_out, is_store_out, tgts_cr_out,
                     priv_type_out, crmov_mode_type_out, alu_result_out_1, alu_result_out_2,
                     mem_result_out, addr_out, exc_out};

  always @(negedge clk) begin
    if (!rst) begin
      if (bubble_out == 1'b0) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL unexpected_emit: got slot %h expected none", out_slot);
        end else begin
          chk("slot", out_slot, exp_q.pop_front());
        end
      end
      if (mem_req && !req_seen) begin
        logic [RW-1:0] e;
        req_seen = 1'b1;
        if (req_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL unexpected_req: got addr %h expected no request", mem_addr);
        end else begin
          e = req_q.pop_front();
          chk("req", {mem_we, mem_addr, mem_be, (e[RW-1] ? mem_wdata : 32'h0)}, e);
        end
      end
      if (!mem_req) req_seen = 1'b0;
    end
  end

  // ---------------- model ----------------
  function automatic logic [RW-1:0] model_req(input in_t s);
    int size, off;
    logic [63:0] m, w;
    logic [3:0] be;
    if (!s.st) return {1'b0, s.addr & 32'hFFFF_FFFC, 4'hF, 32'h0};
    if (s.opcode >= 6 && s.opcode <= 8)       size = 2;
    else if (s.opcode >= 9 && s.opcode <= 11) size = 1;
    else                                       size = 4;
    if (size == 4)      off = 0;
    else if (size == 1) off = int'(s.addr[1:0]);
    else                off = s.addr[1] ? 2 : (s.addr[0] ? 1 : 0);
    be = 4'(((1 << size) - 1) << off);
    m  = (64'h1 << (8 * size)) - 64'h1;
    w  = ({32'h0, s.sdata} & m) << (8 * off);
    return {1'b1, s.addr & 32'hFFFF_FFFC, be, w[31:0]};
  endfunction

  function automatic logic [W-1:0] model_slot(input in_t s, input logic [31:0] rdata,
                                              input logic err, input logic memop);
    logic [31:0] mres;
    logic [7:0]  exc;
    mres = (memop && s.ld && !s.st && !err) ? rdata : 32'h0;
    exc  = (memop && err) ? (s.st ? 8'h83 : 8'h82) : s.exc;
    return {s.opcode, s.tgt1, s.tgt2, s.ld, s.st, s.cr, s.priv, s.crmov,
            s.alu1, s.alu2, mres, s.addr, exc};
  endfunction

  function automatic in_t mk(input logic [4:0] op, input logic [4:0] t1, input logic ld,
                             input logic st, input logic [31:0] alu1, input logic [31:0] addr,
                             input logic [31:0] sdata, input logic [7:0] exc);
    in_t s;
    s.opcode = op;  s.tgt1 = t1;  s.tgt2 = t1 + 5'd1;
    s.ld = ld;  s.st = st;  s.cr = op[0];
    s.priv = op ^ 5'h3;  s.crmov = op[1:0];
    s.alu1 = alu1;  s.alu2 = alu1 ^ 32'h5A5A_5A5A;
    s.addr = addr;  s.sdata = sdata;  s.exc = exc;  s.bub = 1'b0;
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input in_t s);
    bubble_in = s.bub;  opcode_in = s.opcode;  tgt_in_1 = s.tgt1;  tgt_in_2 = s.tgt2;
    is_load_in = s.ld;  is_store_in = s.st;  tgts_cr_in = s.cr;  priv_type_in = s.priv;
    crmov_mode_type_in = s.crmov;  alu_result_in_1 = s.alu1;  alu_result_in_2 = s.alu2;
    addr_in = s.addr;  store_data_in = s.sdata;  exc_in = s.exc;
  endtask

  task automatic capture(input in_t s);
    drive(s);
    @(posedge clk); #1;
    bubble_in = 1'b1;
  endtask

  // Runs one slot to completion; returns #1 after the edge that emits it.
  task automatic run_slot(input in_t s, input int rdy_dly, input int rv_dly,
                          input logic [31:0] rdata, input logic err);
    logic memop;
    memop = !s.bub && (s.exc == 8'h0) && (s.ld || s.st);
    if (!s.bub) exp_q.push_back(model_slot(s, rdata, err, memop));
    if (memop) req_q.push_back(model_req(s));
    capture(s);
    if (!memop) return;
    chk("req_rise", mem_req, 1'b1);
    lr_we = mem_we;  lr_addr = mem_addr;  lr_be = mem_be;  lr_wdata = mem_wdata;
    for (int i = 0; i < rdy_dly; i++) begin
      chk("stall_req", stall_out, 1'b1);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("stall_wait", stall_out, 1'b1);
    for (int i = 0; i < rv_dly; i++) begin
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b1;  mem_rdata = rdata;  mem_err = err;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;  mem_rdata = 32'h0;  mem_err = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  in_t s;
  logic [31:0] alu_tab[4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1357_9BDF};
  logic [4:0]  op_tab[4]  = '{5'd0, 5'd2, 5'd12, 5'd31};
  logic [4:0]  st_ops[6]  = '{5'd3, 5'd5, 5'd7, 5'd8, 5'd10, 5'd11};

  initial begin
    rst = 1'b1;  clk_en = 1'b1;  flush = 1'b0;
    mem_ready = 1'b0;  mem_rvalid = 1'b0;  mem_rdata = 32'h0;  mem_err = 1'b0;
    s = mk(5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 8'h0);
    s.bub = 1'b1;
    drive(s);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bubble", bubble_out, 1'b1);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_be", mem_be, 4'h0);
    chk("rst_stall", stall_out, 1'b0);
    chk("rst_state", fsm_state, 2'd0);
    chk("rst_opcode", opcode_out, 5'h0);
    chk("rst_alu1", alu_result_out_1, 32'h0);
    chk("rst_mres", mem_result_out, 32'h0);
    chk("rst_addr", addr_out, 32'h0);
    chk("rst_exc", exc_out, 8'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ALU slot: one-cycle pass-through
    run_slot(mk(5'd1, 5'd5, 1'b0, 1'b0, 32'h1234, 32'h40, 32'h0, 8'h0), 0, 0, 32'h0, 1'b0);
    chk("alu_bubble", bubble_out, 1'b0);
    chk("alu_result", alu_result_out_1, 32'h1234);
    chk("alu_tgt", tgt_out_1, 5'd5);
    chk("alu_stall", stall_out, 1'b0);
    for (int i = 0; i < 4; i++)
      run_slot(mk(op_tab[i], 5'(i + 7), 1'b0, 1'b0, alu_tab[i], alu_tab[i] + 32'd4, 32'h0, 8'h0),
               0, 0, 32'h0, 1'b0);

    // Excepting load passes straight through; input bubble emits nothing
    run_slot(mk(5'd3, 5'd2, 1'b1, 1'b0, 32'h77, 32'h3000, 32'h0, 8'h05), 0, 0, 32'h0, 1'b0);
    chk("exc_pass_exc", exc_out, 8'h05);
    chk("exc_pass_req", mem_req, 1'b0);
    s = mk(5'd1, 5'd3, 1'b0, 1'b0, 32'h99, 32'h0, 32'h0, 8'h0);
    s.bub = 1'b1;
    run_slot(s, 0, 0, 32'h0, 1'b0);
    chk("bubble_pass", bubble_out, 1'b1);

    // Byte store, rvalid two cycles after mem_ready
    run_slot(mk(5'd9, 5'd4, 1'b0, 1'b1, 32'h1003, 32'h1003, 32'hAB, 8'h0), 0, 1, 32'h0, 1'b0);
    chk("sb_addr", lr_addr, 32'h1000);
    chk("sb_be", lr_be, 4'b1000);
    chk("sb_wdata", lr_wdata, 32'hAB00_0000);
    chk("sb_we", lr_we, 1'b1);
    chk("sb_emit", bubble_out, 1'b0);

    // Load with mem_ready delayed 3 cycles
    run_slot(mk(5'd4, 5'd6, 1'b1, 1'b0, 32'h2000, 32'h2000, 32'h0, 8'h0), 3, 0, 32'hDEAD_BEEF, 1'b0);
    chk("ld_mres", mem_result_out, 32'hDEAD_BEEF);
    chk("ld_bubble", bubble_out, 1'b0);
    @(posedge clk); #1;
    chk("ld_one_cycle", bubble_out, 1'b1);

    // Half stores
    run_slot(mk(5'd6, 5'd8, 1'b0, 1'b1, 32'h0, 32'h2001, 32'h1234, 8'h0), 0, 0, 32'h0, 1'b0);
    chk("sh01_be", lr_be, 4'b0110);
    chk("sh01_wdata", lr_wdata, 32'h0012_3400);
    run_slot(mk(5'd6, 5'd8, 1'b0, 1'b1, 32'h0, 32'h2002, 32'h1234, 8'h0), 1, 0, 32'h0, 1'b0);
    chk("sh10_be", lr_be, 4'b1100);
    chk("sh10_wdata", lr_wdata, 32'h1234_0000);

    // Store lane sweep with unmasked data, every opcode group and offset
    for (int i = 0; i < 6; i++)
      for (int a = 0; a < 4; a++)
        run_slot(mk(st_ops[i], 5'(a), 1'b0, 1'b1, 32'(i), 32'h5000 + 32'(a), 32'hCAFE_F0AB, 8'h0),
                 a % 2, i % 2, 32'h0, 1'b0);

    // Faulting responses
    run_slot(mk(5'd5, 5'd9, 1'b1, 1'b0, 32'h1, 32'h6004, 32'h0, 8'h0), 0, 0, 32'h1111_2222, 1'b1);
    chk("ld_err_exc", exc_out, 8'h82);
    chk("ld_err_mres", mem_result_out, 32'h0);
    run_slot(mk(5'd10, 5'd9, 1'b0, 1'b1, 32'h2, 32'h6005, 32'h55, 8'h0), 0, 0, 32'h0, 1'b1);
    chk("st_err_exc", exc_out, 8'h83);

    // Flush in WAIT -> DRAIN, late rvalid discarded
    s = mk(5'd4, 5'd10, 1'b1, 1'b0, 32'h3, 32'h7000, 32'h0, 8'h0);
    req_q.push_back(model_req(s));
    capture(s);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;  flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("drain_state", fsm_state, 2'd3);
    chk("drain_stall", stall_out, 1'b1);
    @(posedge clk); #1;
    mem_rvalid = 1'b1;  mem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;  mem_rdata = 32'h0;
    chk("drain_done_stall", stall_out, 1'b0);
    chk("drain_done_bubble", bubble_out, 1'b1);

    // Flush in REQ without mem_ready abandons the request
    s = mk(5'd3, 5'd11, 1'b1, 1'b0, 32'h4, 32'h7100, 32'h0, 8'h0);
    req_q.push_back(model_req(s));
    capture(s);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("req_flush_stall", stall_out, 1'b0);
    chk("req_flush_req", mem_req, 1'b0);

    // Flush in WAIT together with rvalid: response dropped, back to IDLE
    s = mk(5'd3, 5'd12, 1'b1, 1'b0, 32'h5, 32'h7200, 32'h0, 8'h0);
    req_q.push_back(model_req(s));
    capture(s);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;  flush = 1'b1;  mem_rvalid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;  mem_rvalid = 1'b0;
    chk("wait_flush_state", fsm_state, 2'd0);
    chk("wait_flush_bubble", bubble_out, 1'b1);

    // Flush while capturing in IDLE drops the slot
    drive(mk(5'd1, 5'd13, 1'b0, 1'b0, 32'h66, 32'h0, 32'h0, 8'h0));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;  bubble_in = 1'b1;
    chk("idle_flush_bubble", bubble_out, 1'b1);

    // clk_en low in REQ: mem_ready ignored, request held
    s = mk(5'd5, 5'd14, 1'b1, 1'b0, 32'h6, 32'h7300, 32'h0, 8'h0);
    exp_q.push_back(model_slot(s, 32'h0BAD_CAFE, 1'b0, 1'b1));
    req_q.push_back(model_req(s));
    capture(s);
    clk_en = 1'b0;  mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("hold_state", fsm_state, 2'd1);
    chk("hold_req", mem_req, 1'b1);
    clk_en = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("hold_wait", fsm_state, 2'd2);
    mem_rvalid = 1'b1;  mem_rdata = 32'h0BAD_CAFE;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;  mem_rdata = 32'h0;
    chk("hold_mres", mem_result_out, 32'h0BAD_CAFE);

    repeat (3) @(posedge clk);
    #1;
    chk("slots_all_emitted", 32'(exp_q.size()), 32'd0);
    chk("reqs_all_seen", 32'(req_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
